// File: rtl/uart_rx_debug_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling ratio and the
// majority vote used by both directions of the board debug link.
package uart_rx_debug_pkg;

  localparam int UART_OVERSAMPLE = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick divider: one-clk tick every TICK_DIV clocks, with a
// synchronous restart so bit timing can be re-aligned to a start edge.
module uart_baud_tick
  import uart_rx_debug_pkg::*;
#(
  parameter int TICK_DIV = 27
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A tick is never issued in the restart cycle; counting resumes from 0.
  assign tick_o = !restart_i && (cnt_q == CNT_LAST);

  always_comb begin
    if (restart_i || tick_o) cnt_d = '0;
    else                     cnt_d = cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_debug.sv
// 8N1 debug-link UART receiver: 16x oversampling, 2-FF sync, 3-sample
// majority, one-entry holding register with valid/ready and sticky errors.
module uart_rx_debug
  import uart_rx_debug_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun_err,
  input  logic       err_clear,
  output logic       busy
);

  localparam int TICK_DIV_RAW = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int TICK_DIV     = (TICK_DIV_RAW < 1) ? 1 : TICK_DIV_RAW;

  logic       rx_meta_q, rx_sync_q;
  logic [2:0] state_q, state_d;
  logic [3:0] phase_q, phase_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic       samp7_q, samp7_d, samp8_q, samp8_d;
  logic       deliver_q, deliver_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       frame_err_q, frame_err_d;
  logic       overrun_q, overrun_d;
  logic       tick, restart, decide, maj, frame_set, overrun_set;

  uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk       (clk),
    .reset_n   (reset_n),
    .restart_i (restart),
    .tick_o    (tick)
  );

  assign decide = tick && (phase_q == 4'd9);
  assign maj    = majority3(samp7_q, samp8_q, rx_sync_q);

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    samp7_d   = samp7_q;
    samp8_d   = samp8_q;
    deliver_d = 1'b0;
    frame_set = 1'b0;
    restart   = 1'b0;

    if (state_q != ST_IDLE && tick) begin
      phase_d = phase_q + 4'd1;
      if (phase_q == 4'd7) samp7_d = rx_sync_q;
      if (phase_q == 4'd8) samp8_d = rx_sync_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (!rx_sync_q) begin
          state_d = ST_START;
          phase_d = 4'd0;
          restart = 1'b1;
        end
      end
      ST_START: begin
        if (decide) begin
          if (!maj) begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (decide) begin
          shift_d   = {maj, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
        end
      end
      // Leaving at the mid-bit decision leaves half a bit to catch the next start edge.
      ST_STOP: begin
        if (decide) begin
          if (maj) begin
            deliver_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rx_sync_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_set = 1'b0;
    if (deliver_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_set = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    // A flag being set in the same cycle as err_clear wins.
    frame_err_d = frame_set | (frame_err_q & ~err_clear);
    overrun_d   = overrun_set | (overrun_q & ~err_clear);
  end

  // NOTE: every flop is reset here, including the data register; the
  // synchronizer presets to idle-high so release never fakes a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      state_q     <= ST_IDLE;
      phase_q     <= 4'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'd0;
      samp7_q     <= 1'b1;
      samp8_q     <= 1'b1;
      deliver_q   <= 1'b0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx_in;
      rx_sync_q   <= rx_meta_q;
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      samp7_q     <= samp7_d;
      samp8_q     <= samp8_d;
      deliver_q   <= deliver_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
